// File: rtl/board_ctl_if.sv
// Command/response bus of the board controller: one command in flight, single-cycle response pulse.
interface board_ctl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       resp_valid;
    logic [1:0] resp_code;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y,
        input  cmd_ready, resp_valid, resp_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y,
        output cmd_ready, resp_valid, resp_code
    );
endinterface

// File: rtl/board_ctl.sv
// 10x10 battleship board controller: PLACE/SHOOT/CLEAR commands, hit/ship counters,
// and a 100-cycle sweep that wipes the board one cell per cycle.
module board_ctl #(
    parameter int SHIP_CELLS = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    board_ctl_if.slave              bus,
    output logic [6:0]              ship_cnt,
    output logic [6:0]              hit_cnt,
    output logic                    all_sunk,
    output logic [0:9][0:9][1:0]    game_board
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR, RESP} state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PLACE = 2'b01;
    localparam logic [1:0] OP_SHOOT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] RC_OK      = 2'b00;
    localparam logic [1:0] RC_HIT     = 2'b01;
    localparam logic [1:0] RC_REPEAT  = 2'b10;
    localparam logic [1:0] RC_INVALID = 2'b11;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [3:0]             x_q, x_d;
    logic [3:0]             y_q, y_d;
    logic [0:9][0:9][1:0]   board_q, board_d;
    logic [6:0]             ship_cnt_q, ship_cnt_d;
    logic [6:0]             hit_cnt_q, hit_cnt_d;
    logic                   all_sunk_q, all_sunk_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [1:0]             resp_code_q, resp_code_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [6:0]             clr_idx_q, clr_idx_d;

    logic       wr_en;
    logic [1:0] wr_val;
    logic [1:0] cur_cell;
    logic       in_range;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        board_d     = board_q;
        ship_cnt_d  = ship_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        resp_code_d = resp_code_q;
        clr_idx_d   = clr_idx_q;
        wr_en       = 1'b0;
        wr_val      = CELL_EMPTY;
        cur_cell    = CELL_EMPTY;
        in_range    = (x_q <= 4'd9) && (y_q <= 4'd9);

        for (int yi = 0; yi < 10; yi++) begin
            for (int xi = 0; xi < 10; xi++) begin
                if (y_q == 4'(yi) && x_q == 4'(xi)) begin
                    cur_cell = board_q[yi][xi];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d = bus.cmd_op;
                    x_d  = bus.cmd_x;
                    y_d  = bus.cmd_y;
                    if (bus.cmd_op == OP_CLEAR) begin
                        state_d    = CLEAR;
                        ship_cnt_d = '0;
                        hit_cnt_d  = '0;
                        clr_idx_d  = '0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d     = RESP;
                resp_code_d = RC_OK;
                case (op_q)
                    OP_PLACE: begin
                        if (!in_range) begin
                            resp_code_d = RC_INVALID;
                        end else if (cur_cell != CELL_EMPTY) begin
                            resp_code_d = RC_REPEAT;
                        end else if (ship_cnt_q < 7'(SHIP_CELLS)) begin
                            wr_en      = 1'b1;
                            wr_val     = CELL_SHIP;
                            ship_cnt_d = ship_cnt_q + 7'd1;
                        end else begin
                            resp_code_d = RC_INVALID;
                        end
                    end
                    OP_SHOOT: begin
                        if (!in_range) begin
                            resp_code_d = RC_INVALID;
                        end else if (cur_cell == CELL_EMPTY) begin
                            wr_en  = 1'b1;
                            wr_val = CELL_MISS;
                        end else if (cur_cell == CELL_SHIP) begin
                            wr_en       = 1'b1;
                            wr_val      = CELL_HIT;
                            hit_cnt_d   = hit_cnt_q + 7'd1;
                            resp_code_d = RC_HIT;
                        end else begin
                            resp_code_d = RC_REPEAT;
                        end
                    end
                    default: resp_code_d = RC_OK;
                endcase
            end
            CLEAR: begin
                if (clr_idx_q == 7'd99) begin
                    state_d     = RESP;
                    resp_code_d = RC_OK;
                end else begin
                    clr_idx_d = clr_idx_q + 7'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Sweep index maps row-major onto the board: idx = y*10 + x.
        for (int yi = 0; yi < 10; yi++) begin
            for (int xi = 0; xi < 10; xi++) begin
                if (wr_en && y_q == 4'(yi) && x_q == 4'(xi)) begin
                    board_d[yi][xi] = wr_val;
                end
                if (state_q == CLEAR && clr_idx_q == 7'(yi * 10 + xi)) begin
                    board_d[yi][xi] = CELL_EMPTY;
                end
            end
        end

        all_sunk_d   = (ship_cnt_d != 7'd0) && (hit_cnt_d == ship_cnt_d);
        resp_valid_d = (state_d == RESP);
        cmd_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            x_q          <= '0;
            y_q          <= '0;
            board_q      <= '0;
            ship_cnt_q   <= '0;
            hit_cnt_q    <= '0;
            all_sunk_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RC_OK;
            cmd_ready_q  <= 1'b0;
            clr_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            x_q          <= x_d;
            y_q          <= y_d;
            board_q      <= board_d;
            ship_cnt_q   <= ship_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            all_sunk_q   <= all_sunk_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            cmd_ready_q  <= cmd_ready_d;
            clr_idx_q    <= clr_idx_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_code  = resp_code_q;
    assign ship_cnt       = ship_cnt_q;
    assign hit_cnt        = hit_cnt_q;
    assign all_sunk       = all_sunk_q;
    assign game_board     = board_q;
endmodule

// File: tb/tb_board_ctl.sv
// Directed bench for board_ctl: a command-level board model plus a per-cycle compare process.
module tb_board_ctl;
    localparam int SHIP = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [6:0]           ship_cnt;
    logic [6:0]           hit_cnt;
    logic                 all_sunk;
    logic [0:9][0:9][1:0] game_board;

    board_ctl_if bus_if ();

    board_ctl #(.SHIP_CELLS(SHIP)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .ship_cnt   (ship_cnt),
        .hit_cnt    (hit_cnt),
        .all_sunk   (all_sunk),
        .game_board (game_board)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Command-level model: effects applied at the accept edge, timing tracked as a busy countdown.
    int mb [10][10];
    int ms, mh;
    int busy;
    bit exp_ready, exp_rv, rst_seen, model_init;
    int exp_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic apply(input int op, input int x, input int y, output int code);
        code = 0;
        if (op == 3) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++) mb[r][c] = 0;
            ms = 0;
            mh = 0;
        end else if (op == 1 || op == 2) begin
            if (x > 9 || y > 9) code = 3;
            else if (op == 1) begin
                if (mb[y][x] != 0) code = 2;
                else if (ms >= SHIP) code = 3;
                else begin mb[y][x] = 1; ms++; end
            end else begin
                if (mb[y][x] == 0) mb[y][x] = 2;
                else if (mb[y][x] == 1) begin mb[y][x] = 3; mh++; code = 1; end
                else code = 2;
            end
        end
    endtask

    task automatic model_step();
        int code;
        if (!rst) begin
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++) mb[r][c] = 0;
            ms = 0; mh = 0; busy = 0;
            exp_ready = 0; exp_rv = 0; exp_code = 0;
            rst_seen = 1; model_init = 1;
        end else begin
            rst_seen = 0;
            if (busy > 0) begin
                busy--;
                exp_rv    = (busy == 1);
                exp_ready = (busy == 0);
            end else begin
                exp_rv = 0;
                if (exp_ready && bus_if.cmd_valid) begin
                    apply(int'(bus_if.cmd_op), int'(bus_if.cmd_x), int'(bus_if.cmd_y), code);
                    exp_code  = code;
                    busy      = (bus_if.cmd_op == 2'b11) ? 101 : 2;
                    exp_ready = 0;
                end else begin
                    exp_ready = 1;
                end
            end
        end
    endtask

    task automatic compare_cycle();
        int bad;
        int by, bx;
        if (!model_init) return;
        check("cmd_ready", 32'(bus_if.cmd_ready), 32'(exp_ready));
        check("resp_valid", 32'(bus_if.resp_valid), 32'(exp_rv));
        if (exp_rv) check("resp_code", 32'(bus_if.resp_code), 32'(exp_code));
        if (exp_ready || exp_rv || rst_seen) begin
            check("ship_cnt", 32'(ship_cnt), 32'(ms));
            check("hit_cnt", 32'(hit_cnt), 32'(mh));
            check("all_sunk", 32'(all_sunk), 32'(ms != 0 && mh == ms));
            bad = 0; by = 0; bx = 0;
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++)
                    if (game_board[r][c] !== 2'(mb[r][c])) begin
                        if (bad == 0) begin by = r; bx = c; end
                        bad++;
                    end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL game_board at %0t: %0d cells differ, first [%0d][%0d] got %0d expected %0d",
                         $time, bad, by, bx, game_board[by][bx], mb[by][bx]);
            end
        end
    endtask

    initial forever begin @(posedge clk); model_step(); end
    initial forever begin @(negedge clk); compare_cycle(); end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic [1:0] op, input int x, input int y,
                          input logic [1:0] exp_c, input int exp_lat, input bit hold);
        int guard, lat;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = op;
        bus_if.cmd_x     = 4'(x);
        bus_if.cmd_y     = 4'(y);
        guard = 0;
        while (!bus_if.cmd_ready && guard < 300) begin @(negedge clk); guard++; end
        if (guard >= 300) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout op=%0d: cmd_ready stayed 0, required 1", op);
            bus_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold) bus_if.cmd_op = 2'b00;
        else bus_if.cmd_valid = 1'b0;
        lat = 1;
        while (!bus_if.resp_valid && lat < 300) begin @(posedge clk); lat++; @(negedge clk); end
        check("resp_seen", 32'(bus_if.resp_valid), 32'd1);
        check("resp_literal_code", 32'(bus_if.resp_code), 32'(exp_c));
        check("resp_latency", 32'(lat), 32'(exp_lat));
        $display("cmd op=%0d x=%0d y=%0d -> code=%0d latency=%0d", op, x, y, bus_if.resp_code, lat);
        if (hold) begin
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            bus_if.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        int nz;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'b00;
        bus_if.cmd_x     = 4'd0;
        bus_if.cmd_y     = 4'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus_if.cmd_ready), 32'd0);
        check("reset_ship_cnt", 32'(ship_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(bus_if.cmd_ready), 32'd1);

        // Place then shoot the same cell
        do_cmd(2'b01, 3, 4, 2'b00, 2, 0);
        do_cmd(2'b10, 3, 4, 2'b01, 2, 0);
        check("cell_4_3", 32'(game_board[4][3]), 32'd3);
        check("lit_ship_cnt_1", 32'(ship_cnt), 32'd1);
        check("lit_hit_cnt_1", 32'(hit_cnt), 32'd1);
        check("lit_all_sunk_1", 32'(all_sunk), 32'd1);

        do_cmd(2'b11, 0, 0, 2'b00, 101, 0);

        // Miss, repeat shot, place onto a miss
        do_cmd(2'b10, 0, 0, 2'b00, 2, 0);
        check("cell_0_0_miss", 32'(game_board[0][0]), 32'd2);
        do_cmd(2'b10, 0, 0, 2'b10, 2, 0);
        do_cmd(2'b01, 0, 0, 2'b10, 2, 0);
        check("cell_0_0_still_miss", 32'(game_board[0][0]), 32'd2);

        // Out-of-range coordinates and NOP
        do_cmd(2'b10, 10, 2, 2'b11, 2, 0);
        do_cmd(2'b01, 5, 15, 2'b11, 2, 0);
        do_cmd(2'b00, 7, 7, 2'b00, 2, 0);

        // Fill to capacity; the 21st placement is refused
        for (int i = 1; i <= 21; i++)
            do_cmd(2'b01, i % 10, i / 10, (i <= 20) ? 2'b00 : 2'b11, 2, 0);
        check("lit_ship_cnt_20", 32'(ship_cnt), 32'd20);
        check("cell_2_1_empty", 32'(game_board[2][1]), 32'd0);
        do_cmd(2'b10, 1, 0, 2'b01, 2, 0);
        do_cmd(2'b10, 1, 0, 2'b10, 2, 0);
        check("lit_hit_cnt_1b", 32'(hit_cnt), 32'd1);
        check("lit_all_sunk_0", 32'(all_sunk), 32'd0);

        // Clear a populated board with cmd_valid held high throughout
        do_cmd(2'b11, 0, 0, 2'b00, 101, 1);
        check("lit_ship_cnt_clr", 32'(ship_cnt), 32'd0);
        check("cell_0_1_clr", 32'(game_board[0][1]), 32'd0);

        // Reset in the middle of a clear sweep
        do_cmd(2'b01, 5, 5, 2'b00, 2, 0);
        do_cmd(2'b01, 9, 9, 2'b00, 2, 0);
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_op    = 2'b11;
        while (!bus_if.cmd_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_clear_cell_9_9", 32'(game_board[9][9]), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        nz = 0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                if (game_board[r][c] != 2'b00) nz++;
        check("abort_nonzero_cells", 32'(nz), 32'd0);
        check("abort_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready_after_release", 32'(bus_if.cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("abort_no_resp", 32'(bus_if.resp_valid), 32'd0);

        do_cmd(2'b01, 2, 2, 2'b00, 2, 0);
        check("lit_ship_cnt_after_abort", 32'(ship_cnt), 32'd1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/board_ctl.md
BOARD_CTL -- requirements
Module: board_ctl

Interface
REQ-001 Parameter SHIP_CELLS, default 20, is the maximum number of ship cells that may be placed on the board.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  2  command: 00 NOP, 01 PLACE, 10 SHOOT, 11 CLEAR.
REQ-007 cmd_x  input  4  column index, valid range 0..9.
REQ-008 cmd_y  input  4  row index, valid range 0..9.
REQ-009 resp_valid  output  1  single-cycle completion pulse.
REQ-010 resp_code  output  2  result: 00 OK/MISS, 01 HIT, 10 REPEAT, 11 INVALID; valid only while resp_valid=1.
REQ-011 ship_cnt  output  7  number of placed ship cells.
REQ-012 hit_cnt  output  7  number of hit ship cells.
REQ-013 all_sunk  output  1  all placed ship cells are hit.
REQ-014 game_board  output  2 bits x [0:9][0:9]  registered board, indexed [y][x]; cell codes 00 empty, 01 ship, 10 miss, 11 hit.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, CLEAR and RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1, and cmd_op/cmd_x/cmd_y SHALL be latched on that edge.
REQ-017 On acceptance, IDLE SHALL go to CLEAR if cmd_op=11, otherwise to EXEC.
REQ-018 EXEC SHALL last one cycle: the board/counter update and resp_code are registered at its end, and the FSM then goes to RESP.
REQ-019 RESP SHALL last one cycle with resp_valid=1, then go to IDLE; the accept-edge-to-resp_valid latency is 2 cycles, and throughput is at most one command per 3 cycles.
REQ-020 Any coordinate greater than 9 on PLACE or SHOOT SHALL give INVALID with no board or counter change.
REQ-021 PLACE: an empty cell with ship_cnt<SHIP_CELLS becomes 01, ship_cnt+1, OK; a cell that is not 00 gives REPEAT, no change; an empty cell with ship_cnt=SHIP_CELLS gives INVALID, no change.
REQ-022 SHOOT: cell 00 becomes 10, code 00 (MISS); cell 01 becomes 11, hit_cnt+1, HIT; cell 10 or 11 gives REPEAT, no change.
REQ-023 NOP SHALL give OK with no change.
REQ-024 CLEAR SHALL zero ship_cnt and hit_cnt on entry, then write 00 to one cell per cycle in row-major order using a 7-bit index 0..99.
REQ-025 After writing cell 99, CLEAR SHALL go to RESP with code OK; CLEAR therefore lasts 100 cycles and resp_valid is asserted 101 cycles after the accept edge.
REQ-026 all_sunk SHALL be registered, equal to (ship_cnt!=0 && hit_cnt==ship_cnt), and updated in the same cycle as the counters.
REQ-027 hit_cnt SHALL never exceed ship_cnt; no counter wrap-around is possible.
REQ-028 Commands presented while cmd_ready=0 SHALL be ignored, with no queuing.

Reset
REQ-029 While rst=0 at a rising edge: all cells 00, ship_cnt=0, hit_cnt=0, all_sunk=0, resp_valid=0, resp_code=00, state IDLE.
REQ-030 cmd_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-031 A reset during EXEC, CLEAR or RESP SHALL abort the operation immediately; no resp_valid is produced for the aborted command, and the board is fully zeroed on the reset edge.

Verification
REQ-032 PLACE (3,4) then SHOOT (3,4) -> OK then HIT; game_board[4][3]=11, ship_cnt=1, hit_cnt=1, all_sunk=1; each resp_valid arrives 2 cycles after its accept edge.
REQ-033 SHOOT (0,0) twice on an empty board -> MISS (cell=10) then REPEAT with no change; PLACE (0,0) -> REPEAT.
REQ-034 SHOOT (10,2) and PLACE (5,15) -> INVALID, board unchanged; 21 PLACEs to distinct cells with SHIP_CELLS=20 -> 20 OK then INVALID, ship_cnt=20.
REQ-035 CLEAR on a populated board -> cmd_ready=0 for 101 cycles, resp_valid with OK, all cells 00, counters 0; cmd_valid held high throughout is not accepted until IDLE.
REQ-036 Assert rst=0 at CLEAR index 50 -> board zeroed on that edge, no resp_valid, cmd_ready=1 the cycle after release.
